// File: rtl/reg_array_fifo_ctrl_if.sv
// Purpose: push/pop requests and register-array/status signals between a producer-consumer pair and the FIFO controller.
// Latency: wiring only, no storage.
// Backpressure: full/empty carry flow control; ovf/unf exist only when FIFO_CTRL_ERR_FLAGS_EN is defined.
interface reg_array_fifo_ctrl_if #(
    parameter int M = 2
);
    logic         push;
    logic         pop;
    logic         wrt_enab;
    logic [M-1:0] wadd;
    logic [M-1:0] radd;
    logic         full;
    logic         empty;
    logic [M:0]   count;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic         ovf;
    logic         unf;

    modport master (
        output push, pop,
        input  wrt_enab, wadd, radd, full, empty, count, ovf, unf
    );
    modport slave (
        input  push, pop,
        output wrt_enab, wadd, radd, full, empty, count, ovf, unf
    );
`else
    modport master (
        output push, pop,
        input  wrt_enab, wadd, radd, full, empty, count
    );
    modport slave (
        input  push, pop,
        output wrt_enab, wadd, radd, full, empty, count
    );
`endif
endinterface

// File: rtl/reg_array_fifo_ctrl.sv
// Purpose: pointer/count controller for a 2^M-entry FIFO built on an external register array (FIFO_CTRL_ERR_FLAGS_EN adds sticky ovf/unf).
// Latency: wrt_enab is combinational (array writes on the same cycle's negedge); pointers/count update on the next posedge.
// Backpressure: push ignored while full, pop ignored while empty; at full a simultaneous push is refused so the head is not overwritten.
module reg_array_fifo_ctrl #(
    parameter int M = 2
) (
    input  logic                 clk,
    input  logic                 clr,
    reg_array_fifo_ctrl_if.slave fifo
);
    localparam logic [M:0]   DEPTH_CNT = (M+1)'(1 << M);
    localparam logic [M:0]   CNT_ONE   = (M+1)'(1);
    localparam logic [M-1:0] PTR_ONE   = M'(1);

    logic [M-1:0] r_wptr;
    logic [M-1:0] r_rptr;
    logic [M:0]   r_count;
    logic         w_full;
    logic         w_empty;
    logic         w_push_acc;
    logic         w_pop_acc;

    // Status decode from the registered count only; clr gates acceptance so reset forces wrt_enab low.
    always_comb begin
        w_full     = (r_count == DEPTH_CNT);
        w_empty    = (r_count == '0);
        w_push_acc = clr & fifo.push & ~w_full;
        w_pop_acc  = clr & fifo.pop  & ~w_empty;
    end

    // Write pointer advances on each accepted push, wrapping naturally at 2^M.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_wptr <= '0;
        end else if (w_push_acc) begin
            r_wptr <= r_wptr + PTR_ONE;
        end
    end

    // Read pointer advances on each accepted pop, wrapping naturally at 2^M.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_rptr <= '0;
        end else if (w_pop_acc) begin
            r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Occupancy: up on push only, down on pop only, held when both or neither are accepted.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_count <= '0;
        end else begin
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic r_ovf;
    logic r_unf;

    // Sticky error flags: a refused push at full or pop at empty latches until clr.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | (fifo.push & w_full);
            r_unf <= r_unf | (fifo.pop  & w_empty);
        end
    end

    assign fifo.ovf = r_ovf;
    assign fifo.unf = r_unf;
`endif

    assign fifo.wrt_enab = w_push_acc;
    assign fifo.wadd     = r_wptr;
    assign fifo.radd     = r_rptr;
    assign fifo.full     = w_full;
    assign fifo.empty    = w_empty;
    assign fifo.count    = r_count;
endmodule

// File: tb/tb_reg_array_fifo_ctrl.sv
// Testbench for reg_array_fifo_ctrl (M=2) with a negedge-capturing register array and a queue-based FIFO model.
// Directed scenarios pin the model with literal values, then randomized push/pop with occasional async clr.
// A negedge compare process checks every output against the model each cycle.
module tb_reg_array_fifo_ctrl;
    localparam int M     = 2;
    localparam int DEPTH = 1 << M;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] din;
    logic [7:0] mem [DEPTH];
    logic [7:0] d_out;

    reg_array_fifo_ctrl_if #(.M(M)) fifo ();

    reg_array_fifo_ctrl #(.M(M)) dut (
        .clk  (clk),
        .clr  (clr),
        .fifo (fifo)
    );

    always #5 clk = ~clk;

    // Register array: captures on negedge when enabled, presents entry at radd.
    always @(negedge clk) if (fifo.wrt_enab === 1'b1) mem[fifo.wadd] <= din;
    assign d_out = mem[fifo.radd];

    // Behavioural model
    logic [7:0] q[$];
    int         wp, rp;
    bit         m_ovf, m_unf;
    bit         chk_on = 1'b0;
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wp = 0;
        rp = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Drive one cycle of requests, then advance the model by what the spec accepts at the edge.
    task automatic step(input bit pu, input bit po, input logic [7:0] d);
        bit ap, apo;
        fifo.push = pu;
        fifo.pop  = po;
        din       = d;
        @(posedge clk);
        if (!clr) begin
            model_reset();
        end else begin
            ap  = pu && (q.size() < DEPTH);
            apo = po && (q.size() > 0);
            if (pu && q.size() == DEPTH) m_ovf = 1'b1;
            if (po && q.size() == 0)     m_unf = 1'b1;
            if (apo) begin
                void'(q.pop_front());
                rp = (rp + 1) % DEPTH;
            end
            if (ap) begin
                q.push_back(d);
                wp = (wp + 1) % DEPTH;
            end
        end
        #1;
    endtask

    // Per-cycle compare against the model, away from the posedge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("wadd",     fifo.wadd,     wp);
            chk("radd",     fifo.radd,     rp);
            chk("count",    fifo.count,    q.size());
            chk("full",     fifo.full,     q.size() == DEPTH);
            chk("empty",    fifo.empty,    q.size() == 0);
            chk("wrt_enab", fifo.wrt_enab, clr && fifo.push && (q.size() < DEPTH));
            if (q.size() > 0) chk("head", d_out, q[0]);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
            chk("ovf", fifo.ovf, m_ovf);
            chk("unf", fifo.unf, m_unf);
`endif
        end
    end

    initial begin
        int hvy;
        bit pu, po;
        clr       = 1'b0;
        fifo.push = 1'b0;
        fifo.pop  = 1'b0;
        din       = '0;
        model_reset();
        chk_on = 1'b1;

        // Reset state with push forced high
        #3;
        fifo.push = 1'b1;
        #1;
        chk("rst_wrt_enab", fifo.wrt_enab, 0);
        chk("rst_empty",    fifo.empty,    1);
        chk("rst_full",     fifo.full,     0);
        chk("rst_count",    fifo.count,    0);
        fifo.push = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b1;

        // Four pushes fill the FIFO
        for (int i = 0; i < 4; i++) begin
            chk("fill_wadd", fifo.wadd, i);
            step(1'b1, 1'b0, 8'(i + 1));
        end
        chk("fill_count", fifo.count, 4);
        chk("fill_full",  fifo.full,  1);
        chk("fill_wadd0", fifo.wadd,  0);

        // Four pops drain in order
        for (int i = 0; i < 4; i++) begin
            chk("drain_radd", fifo.radd, i);
            chk("drain_dout", d_out,     i + 1);
            step(1'b0, 1'b1, 8'h00);
        end
        chk("drain_empty", fifo.empty, 1);
        chk("drain_count", fifo.count, 0);

        // Steady push+pop at count 2 across pointer wrap
        step(1'b1, 1'b0, 8'h05);
        step(1'b1, 1'b0, 8'h06);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 8'(7 + i));
        chk("both_count", fifo.count, 2);
        chk("both_wadd",  fifo.wadd,  0);
        chk("both_radd",  fifo.radd,  2);
        chk("both_head",  d_out,      8'h0B);

        // Push+pop while full: pop only
        step(1'b1, 1'b0, 8'h0D);
        step(1'b1, 1'b0, 8'h0E);
        chk("pre_full", fifo.full, 1);
        fifo.push = 1'b1;
        fifo.pop  = 1'b1;
        #1;
        chk("full_both_we", fifo.wrt_enab, 0);
        step(1'b1, 1'b1, 8'h77);
        chk("full_both_count", fifo.count, 3);
        chk("full_both_radd",  fifo.radd,  3);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        chk("ovf_set", fifo.ovf, 1);
`endif

        // Pop while empty
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        chk("unf_count", fifo.count, 0);
        chk("unf_radd",  fifo.radd,  2);
        chk("unf_wadd",  fifo.wadd,  2);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        chk("unf_set", fifo.unf, 1);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h21);
        chk("unf_hold", fifo.unf, 1);
        step(1'b0, 1'b1, 8'h00);
`endif

        // Asynchronous clr mid-cycle with count 3
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
        chk("pre_clr_count", fifo.count, 3);
        fifo.push = 1'b1;
        din       = 8'hEE;
        #2;
        clr = 1'b0;
        model_reset();
        #1;
        chk("aclr_count", fifo.count,    0);
        chk("aclr_wadd",  fifo.wadd,     0);
        chk("aclr_radd",  fifo.radd,     0);
        chk("aclr_empty", fifo.empty,    1);
        chk("aclr_full",  fifo.full,     0);
        chk("aclr_we",    fifo.wrt_enab, 0);
        @(posedge clk);
        #1;
        clr       = 1'b1;
        fifo.push = 1'b1;
        din       = 8'hA5;
        #1;
        chk("post_clr_we",   fifo.wrt_enab, 1);
        chk("post_clr_wadd", fifo.wadd,     0);
        step(1'b1, 1'b0, 8'hA5);
        chk("post_clr_wadd1", fifo.wadd, 1);
        chk("post_clr_head",  d_out,     8'hA5);

        // Randomized traffic with alternating push-heavy / pop-heavy phases
        for (int i = 0; i < 400; i++) begin
            hvy = ((i / 40) % 2 == 0) ? 75 : 30;
            pu  = ($urandom_range(0, 99) < hvy);
            po  = ($urandom_range(0, 99) < (105 - hvy));
            if ($urandom_range(0, 59) == 0) begin
                #2;
                clr = 1'b0;
                model_reset();
                @(posedge clk);
                #1;
                clr = 1'b1;
            end
            step(pu, po, 8'($urandom));
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
